clk_gate_seq: RTL and testbench

Sequencer that owns the 2-bit clock-gate mode of NDOM source-clock-gated domains and applies mode changes one at a time. Requests arrive on a valid/ready port. Force-gating waits for the target domain to report idle, with a timeout. Every change is followed by a settle window covering the gate cell's mode synchronizer. Sits in the clock/power control block between the register bank and the per-domain source clock gate cells.

---
 rtl/clk_gate_pkg.sv | 24 ++
 rtl/clk_gate_seq.sv | 153 +++++++++++++++
 tb/tb_clk_gate_seq.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/clk_gate_pkg.sv
// Shared clock-gate definitions: mode encodings used by the sequencer and the
// per-domain source clock gate cells, plus the sequencer FSM state type.
package clk_gate_pkg;

  typedef logic [1:0] cg_mode_t;

  localparam cg_mode_t NCLK_GATE  = 2'b00;
  localparam cg_mode_t DYCLK_GATE = 2'b01;
  localparam cg_mode_t FOCLK_GATE = 2'b10;
  localparam cg_mode_t BAD_GATE   = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_WAIT_IDLE,
    ST_SETTLE,
    ST_RESP
  } cg_state_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/clk_gate_seq.sv
// Clock-gate mode sequencer: applies one domain mode change per request, waits
// for domain idle before force-gating, and holds a settle window after each write.
module clk_gate_seq
  import clk_gate_pkg::*;
#(
  parameter int NDOM       = 4,
  parameter int SETTLE_CYC = 8,
  parameter int TIMEOUT    = 255
) (
  input  logic              clk_in,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_dom,
  input  logic [1:0]        req_mode,
  input  logic [NDOM-1:0]   dom_idle,
  output logic [2*NDOM-1:0] cfg_mode,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int CW = int'(max_u($clog2(TIMEOUT), $clog2(SETTLE_CYC)));
  localparam int DW = $clog2(NDOM);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] SET_LAST = CW'(SETTLE_CYC - 1);
  localparam logic [4:0]    NDOM_W   = 5'(NDOM);

  cg_state_t         state_q, state_d;
  logic [CW-1:0]     cnt_q;
  logic [3:0]        dom_q;
  cg_mode_t          mode_q;
  logic              err_flag_q;
  logic [2*NDOM-1:0] cfg_q;
  logic              done_q, err_q;

  logic              accept, cfg_we, cnt_clr, cnt_inc, err_set;
  logic              dom_ok;
  logic [DW-1:0]     dom_idx;
  logic [DW:0]       bit_base;
  cg_mode_t          cur_mode;

  // Index is only meaningful once dom_ok holds; out-of-range reads are never used.
  assign dom_ok   = ({1'b0, dom_q} < NDOM_W);
  assign dom_idx  = dom_q[DW-1:0];
  assign bit_base = {dom_idx, 1'b0};
  assign cur_mode = cfg_q[bit_base +: 2];

  assign req_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign cfg_mode  = cfg_q;
  assign done      = done_q;
  assign err       = err_q;

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    cfg_we  = 1'b0;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    err_set = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          accept  = 1'b1;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (!dom_ok || mode_q == BAD_GATE) begin
          err_set = 1'b1;
          state_d = ST_RESP;
        end else if (mode_q == cur_mode) begin
          state_d = ST_RESP;
        end else if (mode_q != FOCLK_GATE) begin
          cfg_we  = 1'b1;
          cnt_clr = 1'b1;
          state_d = ST_SETTLE;
        end else begin
          cnt_clr = 1'b1;
          state_d = ST_WAIT_IDLE;
        end
      end
      ST_WAIT_IDLE: begin
        if (dom_idle[dom_idx]) begin
          cfg_we  = 1'b1;
          cnt_clr = 1'b1;
          state_d = ST_SETTLE;
        end else if (cnt_q == TO_LAST) begin
          err_set = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == SET_LAST) begin
          state_d = ST_RESP;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q      <= '0;
      dom_q      <= '0;
      mode_q     <= NCLK_GATE;
      err_flag_q <= 1'b0;
      cfg_q      <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      if (accept) begin
        dom_q      <= req_dom;
        mode_q     <= req_mode;
        err_flag_q <= 1'b0;
      end else if (err_set) begin
        err_flag_q <= 1'b1;
      end

      if (cnt_clr) begin
        cnt_q <= '0;
      end else if (cnt_inc) begin
        cnt_q <= cnt_q + 1'b1;
      end

      if (cfg_we) begin
        cfg_q[bit_base +: 2] <= mode_q;
      end

      done_q <= (state_q == ST_RESP) && !err_flag_q;
      err_q  <= (state_q == ST_RESP) &&  err_flag_q;
    end
  end

endmodule

// File: tb/tb_clk_gate_seq.sv
// Scoreboard bench for clk_gate_seq: each request pushes its expected response,
// final cfg_mode and accept-to-pulse latency; the monitor pops on done/err.
module tb_clk_gate_seq;

  localparam int NDOM       = 4;
  localparam int SETTLE_CYC = 8;
  localparam int TIMEOUT    = 255;

  logic              clk_in = 1'b0;
  logic              reset_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [3:0]        req_dom = '0;
  logic [1:0]        req_mode = '0;
  logic [NDOM-1:0]   dom_idle = '0;
  logic [2*NDOM-1:0] cfg_mode;
  logic              busy, done, err;

  clk_gate_seq #(.NDOM(NDOM), .SETTLE_CYC(SETTLE_CYC), .TIMEOUT(TIMEOUT)) dut (
    .clk_in    (clk_in),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_dom   (req_dom),
    .req_mode  (req_mode),
    .dom_idle  (dom_idle),
    .cfg_mode  (cfg_mode),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic              is_err;
    logic [2*NDOM-1:0] cfg;
    int                lat;
  } exp_t;

  exp_t              sb[$];
  logic [2*NDOM-1:0] mdl_cfg = '0;
  int                n_checks = 0;
  int                n_errors = 0;
  int                cyc = 0;
  int                acc_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  always @(posedge clk_in) begin
    if (req_valid && req_ready) acc_cyc <= cyc;
    cyc <= cyc + 1;
  end

  always @(negedge clk_in) begin
    if (done || err) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", {30'd0, done, err}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("both_pulses", 32'(done && err), 32'd0);
        chk("resp_kind", 32'(err), 32'(e.is_err));
        chk("resp_cfg", 32'(cfg_mode), 32'(e.cfg));
        chk("resp_latency", 32'(cyc - acc_cyc - 1), 32'(e.lat));
        chk("busy_at_pulse", 32'(busy), 32'd0);
      end
    end
  end

  // idle_k: low WAIT_IDLE cycles before idle is seen; negative means it never rises.
  task automatic send(input logic [3:0] dom, input logic [1:0] mode, input int idle_k,
                      input bit push);
    exp_t e;
    logic [1:0] cur;
    bit got;
    cur = 2'((mdl_cfg >> (2 * int'(dom))) & 8'h3);
    e.lat = 2;
    e.is_err = 1'b0;
    if (int'(dom) >= NDOM || mode == 2'b11) begin
      e.is_err = 1'b1;
    end else if (cur == mode) begin
      e.lat = 2;
    end else if (mode != 2'b10) begin
      e.lat = SETTLE_CYC + 2;
      mdl_cfg = (mdl_cfg & ~(8'h3 << (2 * int'(dom)))) | (8'(mode) << (2 * int'(dom)));
    end else if (idle_k < 0) begin
      e.is_err = 1'b1;
      e.lat = TIMEOUT + 2;
    end else begin
      e.lat = idle_k + 3 + SETTLE_CYC;
      mdl_cfg = (mdl_cfg & ~(8'h3 << (2 * int'(dom)))) | (8'(mode) << (2 * int'(dom)));
    end
    e.cfg = mdl_cfg;
    @(negedge clk_in);
    req_valid = 1'b1;
    req_dom   = dom;
    req_mode  = mode;
    got = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (req_ready) begin
        got = 1'b1;
        break;
      end
      @(negedge clk_in);
    end
    if (!got) chk("accept_timeout", 32'd0, 32'd1);
    if (push) sb.push_back(e);
    @(posedge clk_in);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk_in);
      if (sb.size() == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    chk("drain", 32'(ok), 32'd1);
  endtask

  initial begin
    repeat (3) @(posedge clk_in);
    #1;
    chk("reset_cfg", 32'(cfg_mode), 32'd0);
    chk("reset_ready", 32'(req_ready), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done_err", {30'd0, done, err}, 32'd0);
    @(negedge clk_in);
    reset_n = 1'b1;

    // Dynamic gate on dom2: cfg changes one edge after accept.
    send(4'd2, 2'b01, 0, 1'b1);
    chk("dyn_cfg_before", 32'(cfg_mode), 32'h00);
    chk("dyn_busy", 32'(busy), 32'd1);
    @(posedge clk_in);
    #1;
    chk("dyn_cfg_after", 32'(cfg_mode), 32'h10);
    drain();

    // Force gate dom1 with idle already high.
    dom_idle = 4'b0010;
    send(4'd1, 2'b10, 0, 1'b1);
    @(posedge clk_in);
    #1;
    chk("fg_cfg_wait", 32'(cfg_mode), 32'h10);
    @(posedge clk_in);
    #1;
    chk("fg_cfg_written", 32'(cfg_mode), 32'h18);
    drain();

    // Force gate dom0 with idle held low: timeout.
    dom_idle = 4'b0000;
    send(4'd0, 2'b10, -1, 1'b1);
    drain();

    // Same request, idle rises after 40 low WAIT_IDLE cycles.
    send(4'd0, 2'b10, 40, 1'b1);
    repeat (41) @(posedge clk_in);
    #1;
    dom_idle = 4'b0001;
    drain();
    dom_idle = 4'b0000;

    // Illegal mode, out-of-range domain, same-mode re-request.
    send(4'd3, 2'b11, 0, 1'b1);
    drain();
    send(4'd7, 2'b01, 0, 1'b1);
    drain();
    send(4'd2, 2'b01, 0, 1'b1);
    drain();

    // Second request held while busy; accepted only after the first completes.
    send(4'd3, 2'b01, 0, 1'b1);
    send(4'd3, 2'b00, 0, 1'b1);
    send(4'd2, 2'b00, 0, 1'b1);
    drain();

    // Reset during WAIT_IDLE aborts silently and clears all modes.
    send(4'd3, 2'b10, -1, 1'b0);
    repeat (10) @(posedge clk_in);
    #1;
    chk("abort_busy_before", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("abort_cfg", 32'(cfg_mode), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    mdl_cfg = '0;
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    reset_n = 1'b1;
    send(4'd0, 2'b01, 0, 1'b1);
    drain();
    repeat (5) @(posedge clk_in);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
